// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Holds the program counter, presents it to a
// combinational-read instruction memory and captures each returned word with
// its PC into a 2-entry output FIFO. Decode drains the FIFO through a
// valid/ready handshake; execute redirects the stream on taken branches/jumps.
//
// Configuration macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a misaligned redirect target produces a single marker entry
//               {redirect_pc, 0, misalign=1} and halts fetch until the next
//               redirect or reset. Adds the out_misalign port.
//   undefined : the low two bits of redirect_pc are dropped on load.
//
// XLEN normally comes from constants.vh; a 32-bit fallback is provided when
// the macro has not been defined by the build.
//
// Ports:
//   clk            : clock
//   reset          : synchronous active-high reset
//   imem_addr      : byte address to instruction memory (always the PC)
//   imem_rdata     : instruction word for imem_addr, same cycle
//   redirect_valid : load redirect_pc this cycle, flush the FIFO
//   redirect_pc    : redirect target
//   out_valid      : FIFO head valid
//   out_ready      : consumer accepts the head
//   out_pc         : PC of the head entry
//   out_inst       : instruction of the head entry
//   out_misalign   : head is a misaligned-target marker (macro only)
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module fetch_unit #(
    parameter logic [`XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [`XLEN-1:0]  imem_addr,
    input  logic [`XLEN-1:0]  imem_rdata,
    input  logic              redirect_valid,
    input  logic [`XLEN-1:0]  redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [`XLEN-1:0]  out_pc,
    output logic [`XLEN-1:0]  out_inst
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic              out_misalign
`endif
);

    localparam int XLEN = `XLEN;

    localparam logic [1:0] COUNT_EMPTY = 2'd0;
    localparam logic [1:0] COUNT_ONE   = 2'd1;
    localparam logic [1:0] COUNT_FULL  = 2'd2;

    logic [XLEN-1:0] pc_reg;
    logic [1:0]      count_reg;
    logic [1:0]      count_next;

    // Slot 0 is always the head; slot 1 shifts down on a pop.
    logic [XLEN-1:0] slot_pc_reg   [2];
    logic [XLEN-1:0] slot_inst_reg [2];
    logic            slot_mis_reg  [2];

    logic            pop;
    logic            push;
    logic            space;
    logic            wr_idx;
    logic [XLEN-1:0] target_pc;
    logic [XLEN-1:0] push_inst;
    logic            push_mis;

    assign imem_addr = pc_reg;
    assign out_valid = (count_reg != COUNT_EMPTY);
    assign out_pc    = slot_pc_reg[0];
    assign out_inst  = slot_inst_reg[0];

    assign pop   = out_valid && out_ready;
    // A full FIFO can still accept a word when the head leaves this cycle.
    assign space = (count_reg != COUNT_FULL) || pop;
    // New entry lands just behind whatever survives this cycle's pop.
    assign wr_idx = (count_reg == COUNT_FULL) || ((count_reg == COUNT_ONE) && !pop);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic halted_reg;
    logic marker_pending_reg;
    logic target_misaligned;

    assign target_misaligned = (redirect_pc[1:0] != 2'b00);
    assign target_pc         = redirect_pc;
    // While halted the only push allowed is the one-shot marker entry.
    assign push      = !redirect_valid && (!halted_reg || marker_pending_reg) && space;
    assign push_inst = marker_pending_reg ? '0 : imem_rdata;
    assign push_mis  = marker_pending_reg;
    assign out_misalign = slot_mis_reg[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            halted_reg         <= 1'b0;
            marker_pending_reg <= 1'b0;
        end else if (redirect_valid) begin
            halted_reg         <= target_misaligned;
            marker_pending_reg <= target_misaligned;
        end else if (push) begin
            marker_pending_reg <= 1'b0;
        end
    end
`else
    // Masking (rather than slicing) keeps every redirect_pc bit in use.
    assign target_pc = redirect_pc & ~XLEN'(3);
    assign push      = !redirect_valid && space;
    assign push_inst = imem_rdata;
    assign push_mis  = 1'b0;
`endif

    always_comb begin
        count_next = count_reg;
        if (redirect_valid) begin
            // Any pop this cycle still completes; the remainder is dropped.
            count_next = COUNT_EMPTY;
        end else if (push && !pop) begin
            count_next = count_reg + 2'd1;
        end else if (pop && !push) begin
            count_next = count_reg - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg    <= RESET_PC;
            count_reg <= COUNT_EMPTY;
        end else begin
            count_reg <= count_next;
            if (redirect_valid) begin
                pc_reg <= target_pc;
            end else if (push && !push_mis) begin
                // Marker entries do not consume a fetch, so the PC holds.
                pc_reg <= pc_reg + XLEN'(4);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (reset) begin
                    slot_pc_reg[gi]   <= '0;
                    slot_inst_reg[gi] <= '0;
                    slot_mis_reg[gi]  <= 1'b0;
                end else if (push && (wr_idx == 1'(gi))) begin
                    slot_pc_reg[gi]   <= pc_reg;
                    slot_inst_reg[gi] <= push_inst;
                    slot_mis_reg[gi]  <= push_mis;
                end else if (pop && (gi == 0)) begin
                    slot_pc_reg[gi]   <= slot_pc_reg[1];
                    slot_inst_reg[gi] <= slot_inst_reg[1];
                    slot_mis_reg[gi]  <= slot_mis_reg[1];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        out_misalign;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign imem_rdata = inst_of(imem_addr);

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .out_misalign   (out_misalign)
`endif
    );

    // One line per completed transfer.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready)
            $display("xfer pc=%08h inst=%08h", out_pc, out_inst);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = ready;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b required=0", out_valid); end
        checks++;
        if (imem_addr !== 32'h100) begin failures++; $display("FAIL reset_addr actual=%h required=%h", imem_addr, 32'h100); end
`ifdef FETCH_MISALIGN_TRAP_EN
        checks++;
        if (out_misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign actual=%b required=0", out_misalign); end
`endif
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_release_valid actual=%b required=0", out_valid); end
        for (int i = 0; i < 3; i++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'h100 + 32'(4 * i);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc || out_inst !== inst_of(exp_pc)) begin
                failures++;
                $display("FAIL reset_stream[%0d] actual=%b/%h/%h required=1/%h/%h", i, out_valid, out_pc, out_inst, exp_pc, inst_of(exp_pc));
            end
        end
    endtask

    task automatic test_stall();
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
                failures++;
                $display("FAIL stall_head[%0d] actual=%b/%h required=1/%h", i, out_valid, out_pc, 32'h100);
            end
        end
        checks++;
        if (imem_addr !== 32'h108) begin failures++; $display("FAIL stall_pc_frozen actual=%h required=%h", imem_addr, 32'h108); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'h100 + 32'(4 * i);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc || out_inst !== inst_of(exp_pc)) begin
                failures++;
                $display("FAIL stall_release[%0d] actual=%b/%h/%h required=1/%h/%h", i, out_valid, out_pc, out_inst, exp_pc, inst_of(exp_pc));
            end
            step();
        end
    endtask

    task automatic test_redirect_pop();
        do_reset(1'b0);
        step();
        step();
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || imem_addr !== 32'h108) begin
            failures++;
            $display("FAIL rp_full actual=%b/%h/%h required=1/%h/%h", out_valid, out_pc, imem_addr, 32'h100, 32'h108);
        end
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h200) begin
            failures++;
            $display("FAIL rp_flush actual=%b/%h required=0/%h", out_valid, imem_addr, 32'h200);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_inst !== inst_of(32'h200)) begin
            failures++;
            $display("FAIL rp_target actual=%b/%h/%h required=1/%h/%h", out_valid, out_pc, out_inst, 32'h200, inst_of(32'h200));
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h204) begin
            failures++;
            $display("FAIL rp_next actual=%b/%h required=1/%h", out_valid, out_pc, 32'h204);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'hFFFF_FFF8;
        exp_seq[1] = 32'hFFFF_FFFC;
        exp_seq[2] = 32'h0000_0000;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_seq[i] || out_inst !== inst_of(exp_seq[i])) begin
                failures++;
                $display("FAIL wrap[%0d] actual=%b/%h/%h required=1/%h/%h", i, out_valid, out_pc, out_inst, exp_seq[i], inst_of(exp_seq[i]));
            end
        end
    endtask

    task automatic test_misalign();
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h202;
        step();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        checks++;
        if (imem_addr !== 32'h202) begin failures++; $display("FAIL mis_addr actual=%h required=%h", imem_addr, 32'h202); end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h202 || out_inst !== 32'h0 || out_misalign !== 1'b1) begin
            failures++;
            $display("FAIL mis_marker actual=%b/%h/%h/%b required=1/%h/0/1", out_valid, out_pc, out_inst, out_misalign, 32'h202);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL mis_halted[%0d] actual=%b required=0", i, out_valid); end
        end
        checks++;
        if (imem_addr !== 32'h202) begin failures++; $display("FAIL mis_halt_addr actual=%h required=%h", imem_addr, 32'h202); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h300 || out_misalign !== 1'b0) begin
            failures++;
            $display("FAIL mis_resume actual=%b/%h/%b required=1/%h/0", out_valid, out_pc, out_misalign, 32'h300);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h304) begin
            failures++;
            $display("FAIL mis_resume_next actual=%b/%h required=1/%h", out_valid, out_pc, 32'h304);
        end
`else
        checks++;
        if (imem_addr !== 32'h200) begin failures++; $display("FAIL align_addr actual=%h required=%h", imem_addr, 32'h200); end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_inst !== inst_of(32'h200)) begin
            failures++;
            $display("FAIL align_target actual=%b/%h/%h required=1/%h/%h", out_valid, out_pc, out_inst, 32'h200, inst_of(32'h200));
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h204) begin
            failures++;
            $display("FAIL align_next actual=%b/%h required=1/%h", out_valid, out_pc, 32'h204);
        end
`endif
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h400;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h400 || imem_addr !== 32'h408) begin
            failures++;
            $display("FAIL rf_full actual=%b/%h/%h required=1/%h/%h", out_valid, out_pc, imem_addr, 32'h400, 32'h408);
        end
        // Reset together with a redirect: reset must win.
        reset = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h500;
        step();
        reset = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL rf_cleared actual=%b/%h required=0/%h", out_valid, imem_addr, 32'h100);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'h100 + 32'(4 * i);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
                failures++;
                $display("FAIL rf_restart[%0d] actual=%b/%h required=1/%h", i, out_valid, out_pc, exp_pc);
            end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h500;
        step();
        redirect_pc = 32'h600;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h600) begin
            failures++;
            $display("FAIL b2b_flush actual=%b/%h required=0/%h", out_valid, imem_addr, 32'h600);
        end
        for (int i = 0; i < 2; i++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'h600 + 32'(4 * i);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc || out_inst !== inst_of(exp_pc)) begin
                failures++;
                $display("FAIL b2b_stream[%0d] actual=%b/%h/%h required=1/%h/%h", i, out_valid, out_pc, out_inst, exp_pc, inst_of(exp_pc));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b0;
        test_reset();
        test_stall();
        test_redirect_pop();
        test_wrap();
        test_misalign();
        test_reset_full();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
